// File: rtl/mult_div_sequencer_pkg.sv
// Shared definitions for the MULT/DIV sequencer: FSM state encoding,
// operation kind, default sizing and the funct codes that select it.
package mult_div_sequencer_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 6;

  localparam logic [5:0] FUNCT_MULT = 6'h18;
  localparam logic [5:0] FUNCT_DIV  = 6'h1a;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MULT_RUN = 3'd1,
    S_DIV_RUN  = 3'd2,
    S_FIX_SIGN = 3'd3,
    S_DONE     = 3'd4,
    S_DIV0     = 3'd5
  } state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_t;

  // Lets the decoder ask whether an R-type funct belongs to this unit.
  function automatic logic is_muldiv_funct(input logic [5:0] funct);
    return (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  endfunction

endpackage

// File: rtl/mult_div_sequencer.sv
// Iterative signed MULT/DIV sequencer. Works on operand magnitudes
// (shift-add multiply, restoring divide, one bit per cycle) and fixes
// the signs in a single cycle before loading HI/LO.
module mult_div_sequencer
  import mult_div_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             hi_write,
  output logic             lo_write,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t state;
  state_t state_next;

  op_t              op;
  logic             sign_a;
  logic             sign_b;
  logic [CNT_W-1:0] cnt;
  logic [W2-1:0]    mcand;
  logic [WIDTH-1:0] opb;
  logic [W2-1:0]    acc;

  // Unsigned magnitude; the most negative value maps onto itself, which
  // is exactly its magnitude when read back as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  // One restoring-division step on {remainder, quotient}: shift left,
  // try subtracting the divisor, keep the result only if it fits.
  function automatic logic [W2-1:0] restore_step(input logic [W2-1:0]    rq,
                                                 input logic [WIDTH-1:0] d);
    logic [WIDTH:0] partial;
    logic [WIDTH:0] diff;
    partial = rq[W2-1:WIDTH-1];
    diff    = partial - {1'b0, d};
    if (diff[WIDTH]) begin
      return {rq[W2-2:0], 1'b0};
    end
    return {diff[WIDTH-1:0], rq[WIDTH-2:0], 1'b1};
  endfunction

  // Converts the unsigned result back to signed form: the product takes
  // sign_a^sign_b, the quotient likewise, the remainder follows the dividend.
  function automatic logic [W2-1:0] apply_signs(input op_t           o,
                                                input logic          sa,
                                                input logic          sb,
                                                input logic [W2-1:0] r);
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] rem;
    if (o == OP_MULT) begin
      return (sa ^ sb) ? -r : r;
    end
    q   = r[WIDTH-1:0];
    rem = r[W2-1:WIDTH];
    if (sa ^ sb) q = -q;
    if (sa) rem = -rem;
    return {rem, q};
  endfunction

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus Moore status outputs.
  always_comb begin
    state_next = state;
    busy       = (state != S_IDLE);
    done       = 1'b0;
    div_zero   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_mult) begin
          state_next = S_MULT_RUN;
        end else if (start_div) begin
          state_next = (b == '0) ? S_DIV0 : S_DIV_RUN;
        end
      end
      S_MULT_RUN, S_DIV_RUN: begin
        if (cnt == LAST_CNT) begin
          state_next = S_FIX_SIGN;
        end
      end
      S_FIX_SIGN: state_next = S_DONE;
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      S_DIV0: begin
        div_zero   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign hi_write = done;
  assign lo_write = done;

  // Datapath: latch operands on accept, iterate, and load HI/LO only
  // in the sign-fix cycle so they stay stable during the next run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op     <= OP_MULT;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      opb    <= '0;
      acc    <= '0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_mult || start_div) begin
            op     <= start_mult ? OP_MULT : OP_DIV;
            sign_a <= a[WIDTH-1];
            sign_b <= b[WIDTH-1];
            cnt    <= '0;
            opb    <= magnitude(b);
            if (start_mult) begin
              mcand <= {{WIDTH{1'b0}}, magnitude(a)};
              acc   <= '0;
            end else begin
              mcand <= '0;
              acc   <= {{WIDTH{1'b0}}, magnitude(a)};
            end
          end
        end
        S_MULT_RUN: begin
          if (opb[0]) begin
            acc <= acc + mcand;
          end
          mcand <= mcand << 1;
          opb   <= opb >> 1;
          cnt   <= cnt + CNT_W'(1);
        end
        S_DIV_RUN: begin
          acc <= restore_step(acc, opb);
          cnt <= cnt + CNT_W'(1);
        end
        S_FIX_SIGN: begin
          {hi_out, lo_out} <= apply_signs(op, sign_a, sign_b, acc);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Self-checking bench for mult_div_sequencer: a cycle-level reference model
// built from signed 64-bit arithmetic, a per-cycle compare process, directed
// literal cases and a randomized operation mix.
module tb_mult_div_sequencer;

  localparam int WIDTH = 32;
  // Accepted op stays busy for WIDTH run cycles, one sign-fix and one done cycle.
  localparam int OP_CYCLES = WIDTH + 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_mult = 1'b0;
  logic        start_div = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_zero, hi_write, lo_write;
  logic [31:0] hi_out, lo_out;

  int checks = 0;
  int failures = 0;
  bit checkEn = 1'b0;

  mult_div_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .a(a), .b(b), .busy(busy), .done(done), .div_zero(div_zero),
    .hi_write(hi_write), .lo_write(lo_write), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Expected {HI, LO} from plain signed arithmetic (truncating division).
  function automatic logic [63:0] referenceResult(input bit isDiv,
                                                  input logic [31:0] av,
                                                  input logic [31:0] bv);
    longint sa, sb, q, r;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    if (!isDiv) return 64'(sa * sb);
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Reference model: mTimer counts cycles left until the unit is idle again.
  int          mTimer = 0;
  bit          mIsDiv0 = 1'b0;
  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;
  logic [63:0] mPending = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mTimer  <= 0;
      mIsDiv0 <= 1'b0;
      mHi     <= '0;
      mLo     <= '0;
    end else if (mTimer == 0) begin
      if (start_mult) begin
        mPending <= referenceResult(1'b0, a, b);
        mTimer   <= OP_CYCLES;
        mIsDiv0  <= 1'b0;
      end else if (start_div) begin
        if (b == 32'd0) begin
          mTimer  <= 1;
          mIsDiv0 <= 1'b1;
        end else begin
          mPending <= referenceResult(1'b1, a, b);
          mTimer   <= OP_CYCLES;
          mIsDiv0  <= 1'b0;
        end
      end
    end else begin
      mTimer <= mTimer - 1;
      if (!mIsDiv0 && mTimer == 2) begin
        mHi <= mPending[63:32];
        mLo <= mPending[31:0];
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("cyc busy", busy, mTimer != 0);
      checkOutput("cyc done", done, !mIsDiv0 && mTimer == 1);
      checkOutput("cyc div_zero", div_zero, mIsDiv0 && mTimer == 1);
      checkOutput("cyc hi_write", hi_write, !mIsDiv0 && mTimer == 1);
      checkOutput("cyc lo_write", lo_write, !mIsDiv0 && mTimer == 1);
      checkOutput("cyc hi_out", hi_out, mHi);
      checkOutput("cyc lo_out", lo_out, mLo);
    end
  end

  // Present a one-cycle start, then scramble the operands.
  task automatic applyStimulus(input bit sm, input bit sd,
                               input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start_mult = sm;
    start_div  = sd;
    a = av;
    b = bv;
    @(negedge clk);
    start_mult = 1'b0;
    start_div  = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  // Wait (bounded) for done or div_zero, counting busy cycles before it;
  // optionally throw spurious starts at the unit while it is busy.
  task automatic waitResult(input int maxCycles, input bit noise,
                            output int busyCount, output bit sawDone,
                            output bit sawDiv0);
    busyCount = 0;
    sawDone   = 1'b0;
    sawDiv0   = 1'b0;
    for (int i = 0; i < maxCycles; i++) begin
      if (done) begin
        sawDone = 1'b1;
        break;
      end
      if (div_zero) begin
        sawDiv0 = 1'b1;
        break;
      end
      if (busy) busyCount++;
      if (noise && busy) begin
        start_mult = ($urandom_range(0, 3) == 0);
        start_div  = ($urandom_range(0, 3) == 0);
        a = $urandom;
        b = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
      end else begin
        start_mult = 1'b0;
        start_div  = 1'b0;
      end
      @(negedge clk);
    end
    start_mult = 1'b0;
    start_div  = 1'b0;
    if (!sawDone && !sawDiv0) checkOutput("result timeout", 0, 1);
  endtask

  task automatic runDirected(input string name, input bit sm, input bit sd,
                             input logic [31:0] av, input logic [31:0] bv,
                             input logic [31:0] expHi, input logic [31:0] expLo);
    int busyCount;
    bit sawDone, sawDiv0;
    applyStimulus(sm, sd, av, bv);
    waitResult(60, 1'b0, busyCount, sawDone, sawDiv0);
    checkOutput({name, " done"}, sawDone, 1);
    checkOutput({name, " latency"}, busyCount, WIDTH + 1);
    checkOutput({name, " hi"}, hi_out, expHi);
    checkOutput({name, " lo"}, lo_out, expLo);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 200);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int busyCount;
    bit sawDone, sawDiv0;

    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkEn = 1'b1;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset hi", hi_out, 0);
    checkOutput("reset lo", lo_out, 0);

    runDirected("mul 7*-3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    checkOutput("mul 7*-3 busy at done", busy, 1);
    runDirected("div -7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runDirected("mul min*min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    runDirected("preload", 1'b0, 1'b1, 32'h2211, 32'h100, 32'h11, 32'h22);

    applyStimulus(1'b0, 1'b1, 32'd5, 32'd0);
    waitResult(60, 1'b0, busyCount, sawDone, sawDiv0);
    checkOutput("div0 pulse", sawDiv0, 1);
    checkOutput("div0 latency", busyCount, 0);
    checkOutput("div0 busy", busy, 1);
    checkOutput("div0 no done", done, 0);
    checkOutput("div0 hi kept", hi_out, 32'h11);
    checkOutput("div0 lo kept", lo_out, 32'h22);
    @(negedge clk);
    checkOutput("div0 busy one cycle", busy, 0);

    runDirected("div min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    runDirected("div 100/7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 32'd14);
    runDirected("div -100/7", 1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2);

    applyStimulus(1'b1, 1'b1, 32'd6, 32'd4);
    waitResult(60, 1'b1, busyCount, sawDone, sawDiv0);
    checkOutput("both starts done", sawDone, 1);
    checkOutput("both starts hi", hi_out, 32'd0);
    checkOutput("both starts lo", lo_out, 32'd24);

    applyStimulus(1'b1, 1'b0, 32'd7, 32'd5);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset busy", busy, 0);
    checkOutput("midreset hi", hi_out, 0);
    checkOutput("midreset lo", lo_out, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    runDirected("mul 3*3", 1'b1, 1'b0, 32'd3, 32'd3, 32'd0, 32'd9);

    for (int n = 0; n < 40; n++) begin
      bit sm, sd, expDiv0;
      logic [31:0] av, bv;
      sm = $urandom_range(0, 1);
      sd = !sm || ($urandom_range(0, 4) == 0);
      av = pickOperand();
      bv = pickOperand();
      expDiv0 = !sm && (bv == 32'd0);
      applyStimulus(sm, sd, av, bv);
      waitResult(60, 1'b1, busyCount, sawDone, sawDiv0);
      checkOutput("rand kind", sawDiv0, expDiv0);
      checkOutput("rand latency", busyCount, expDiv0 ? 0 : WIDTH + 1);
    end

    @(negedge clk);
    checkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
